// File: rtl/csa_accum_sequencer.sv
// ---------------------------------------------------------------------------
// csa_accum_sequencer
//
// Multi-operand accumulation controller built around a 3:2 carry-save stage.
// A job is opened with start/num_terms. Unsigned terms then arrive over a
// valid/ready stream, one per cycle at most. Each term is folded into a
// redundant (sum, carry) pair without any carry propagation. When the last
// term has been folded, a single carry-propagate add resolves the pair. The
// result is then offered on a valid/ready output until it is taken. The sum
// wraps modulo 2^ACC_W and there is no overflow flag.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous reset, active-low (aborts any job)
//   start      in   1      begin a job; only looked at while idle
//   num_terms  in   CNT_W  number of terms in the job, captured with start
//   in_valid   in   1      in_data carries a term
//   in_ready   out  1      a term is accepted this cycle if in_valid is high
//   in_data    in   IN_W   unsigned term, zero-extended to ACC_W
//   out_valid  out  1      out_data holds the job result
//   out_ready  in   1      consumer takes the result
//   out_data   out  ACC_W  sum of all terms of the job, mod 2^ACC_W
//   busy       out  1      a job is in progress (any state but IDLE)
// ---------------------------------------------------------------------------
module csa_accum_sequencer #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_s;
  logic [ACC_W-1:0] r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_out_data;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_s_next;
  logic [ACC_W-1:0] w_c_next;
  logic             w_accept;

  // 3:2 compressor, sum output: bitwise parity of the three operands.
  function automatic logic [ACC_W-1:0] csa_sum(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] x
  );
    return a ^ b ^ x;
  endfunction

  // 3:2 compressor, carry output: bitwise majority moved up one weight.
  // The majority bit of the top position is the carry-out of the ACC_W-bit
  // word, so it is discarded to keep the accumulation modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] csa_carry(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic [ACC_W-1:0] x
  );
    logic [ACC_W-1:0] maj;
    maj = (a & b) | (a & x) | (b & x);
    return {maj[ACC_W-2:0], 1'b0};
  endfunction

  // Carry-propagate resolution of the redundant pair, wrapping modulo 2^ACC_W.
  function automatic logic [ACC_W-1:0] resolve_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    return a + b;
  endfunction

  assign w_x      = ACC_W'(in_data);
  assign w_accept = in_valid & r_in_ready;
  assign w_s_next = csa_sum(r_s, r_c, w_x);
  assign w_c_next = csa_carry(r_s, r_c, w_x);

  // Control and datapath registers.
  // in_ready, out_valid and busy are registered. They are set on the edge
  // that enters the state they describe, so they never glitch. Because only
  // ACCUM raises in_ready and only DONE raises out_valid, the two are never
  // high together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s    <= '0;
            r_c    <= '0;
            r_cnt  <= num_terms;
            r_busy <= 1'b1;
            // An empty job skips straight to resolving the cleared pair,
            // which produces a result of zero.
            if (num_terms != '0) begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= RESOLVE;
            end
          end
        end

        ACCUM: begin
          if (w_accept) begin
            r_s   <= w_s_next;
            r_c   <= w_c_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state    <= RESOLVE;
              r_in_ready <= 1'b0;
            end
          end
        end

        RESOLVE: begin
          r_out_data  <= resolve_add(r_s, r_c);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end

        DONE: begin
          // A start seen in this cycle is deliberately not acted on. The
          // block only samples start once it is back in IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_csa_accum_sequencer.sv
module tb_csa_accum_sequencer;

  localparam int IN_W   = 12;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 5;
  localparam int CNT_WB = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             busy;

  logic              b_start;
  logic [CNT_WB-1:0] b_num;
  logic              b_in_valid;
  logic              b_in_ready;
  logic [IN_W-1:0]   b_in_data;
  logic              b_out_valid;
  logic              b_out_ready;
  logic [ACC_W-1:0]  b_out_data;
  logic              b_busy;

  csa_accum_sequencer #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  csa_accum_sequencer #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_WB)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_terms(b_num),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int job_q[$];
  int b_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer sum of the job's terms, reduced modulo 2^ACC_W.
  function automatic logic [31:0] model_sum(input int q[$]);
    longint s;
    s = 0;
    foreach (q[i]) s += longint'(q[i]);
    return 32'(s % (longint'(1) << ACC_W));
  endfunction

  // Runs one job of job_q on the narrow instance. Expects IDLE on entry and
  // leaves it in IDLE, #1 after the output handshake edge.
  task automatic run_job(input string tag, input int gap_max, input int stall,
                         input bit poke, output logic [ACC_W-1:0] res);
    int n;
    int k;
    int gaps;
    logic [31:0] exp;
    logic [ACC_W-1:0] held;
    n   = job_q.size();
    exp = model_sum(job_q);
    res = '0;
    start = 1'b1;
    num_terms = CNT_W'(n);
    tick();
    // When poke is set, start stays high with a different count all job long.
    start = poke;
    num_terms = poke ? CNT_W'(31) : CNT_W'(0);
    check({tag, "_busy_on"}, 32'(busy), 32'(1));
    check({tag, "_inrdy_open"}, 32'(in_ready), 32'(n != 0));
    foreach (job_q[i]) begin
      gaps = $urandom_range(gap_max, 0);
      repeat (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = IN_W'(job_q[i]);
      k = 0;
      while (!in_ready && k < 20) begin
        tick();
        k++;
      end
      if (k == 20) begin
        check({tag, "_inrdy_timeout"}, 32'(0), 32'(1));
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    // One cycle resolving: nothing offered yet, no term taken.
    check({tag, "_resolve_ovld"}, 32'(out_valid), 32'(0));
    check({tag, "_resolve_irdy"}, 32'(in_ready), 32'(0));
    tick();
    check({tag, "_done_ovld"}, 32'(out_valid), 32'(1));
    check({tag, "_done_irdy"}, 32'(in_ready), 32'(0));
    check({tag, "_result"}, 32'(out_data), exp);
    held = out_data;
    res  = out_data;
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_hold_ovld"}, 32'(out_valid), 32'(1));
      check({tag, "_hold_data"}, 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_ovld"}, 32'(out_valid), 32'(0));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    start = 1'b0;
    num_terms = '0;
  endtask

  task automatic run_job_b(input string tag, output logic [ACC_W-1:0] res);
    int n;
    int k;
    logic [31:0] exp;
    n   = b_q.size();
    exp = model_sum(b_q);
    res = '0;
    b_start = 1'b1;
    b_num = CNT_WB'(n);
    tick();
    b_start = 1'b0;
    foreach (b_q[i]) begin
      b_in_valid = 1'b0;
      if ($urandom_range(3, 0) == 0) tick();
      b_in_valid = 1'b1;
      b_in_data = IN_W'(b_q[i]);
      k = 0;
      while (!b_in_ready && k < 20) begin
        tick();
        k++;
      end
      if (k == 20) begin
        check({tag, "_inrdy_timeout"}, 32'(0), 32'(1));
        b_in_valid = 1'b0;
        return;
      end
      tick();
    end
    b_in_valid = 1'b0;
    check({tag, "_resolve_ovld"}, 32'(b_out_valid), 32'(0));
    tick();
    check({tag, "_done_ovld"}, 32'(b_out_valid), 32'(1));
    check({tag, "_result"}, 32'(b_out_data), exp);
    res = b_out_data;
    tick();
    check({tag, "_idle_busy"}, 32'(b_busy), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [ACC_W-1:0] r;
    logic [ACC_W-1:0] r2;
    rst_n = 1'b0; start = 1'b0; num_terms = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_num = '0; b_in_valid = 1'b0; b_in_data = '0;
    b_out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_b_busy", 32'(b_busy), 32'(0));
    rst_n = 1'b1;
    tick();

    // T1: 5+7+9, back-to-back terms, consumer always ready.
    job_q = '{5, 7, 9};
    run_job("t1", 0, 0, 1'b0, r);
    check("t1_const", 32'(r), 32'(21));

    // T2: empty job.
    job_q = {};
    run_job("t2", 0, 0, 1'b0, r);
    check("t2_const", 32'(r), 32'(0));

    // T3: 31 maximum terms with random valid gaps.
    job_q = {};
    repeat (31) job_q.push_back(4095);
    run_job("t3", 3, 0, 1'b0, r);
    check("t3_const", 32'(r), 32'(126945));

    // T4: start held high during the job (incl. handshake cycle), 10-cycle stall.
    job_q = '{300, 4000};
    run_job("t4", 1, 10, 1'b1, r);
    check("t4_const", 32'(r), 32'(4300));
    tick();
    check("t4_still_idle", 32'(busy), 32'(0));

    // T5: reset aborts a 4-term job after two terms.
    start = 1'b1; num_terms = CNT_W'(4);
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = IN_W'(10);
    tick();
    in_data = IN_W'(20);
    tick();
    in_valid = 1'b0;
    check("t5_mid_irdy", 32'(in_ready), 32'(1));
    rst_n = 1'b0;
    tick();
    check("t5_rst_irdy", 32'(in_ready), 32'(0));
    check("t5_rst_ovld", 32'(out_valid), 32'(0));
    check("t5_rst_busy", 32'(busy), 32'(0));
    check("t5_rst_data", 32'(out_data), 32'(0));
    rst_n = 1'b1;
    tick();
    job_q = '{1, 2};
    run_job("t5", 0, 0, 1'b0, r);
    check("t5_const", 32'(r), 32'(3));

    // T6: back-to-back jobs, start in the cycle right after the handshake.
    job_q = '{1, 1};
    run_job("t6a", 0, 0, 1'b0, r);
    job_q = '{100, 200};
    run_job("t6b", 0, 0, 1'b0, r2);
    check("t6_first", 32'(r), 32'(2));
    check("t6_second", 32'(r2), 32'(300));

    // Randomized jobs: random lengths, terms, gaps and output stalls.
    for (int j = 0; j < 8; j++) begin
      job_q = {};
      repeat ($urandom_range(31, 1)) job_q.push_back(int'($urandom_range(4095, 0)));
      run_job($sformatf("rnd%0d", j), 2, int'($urandom_range(3, 0)), 1'b0, r);
    end

    // Wide-count build: 300 terms, with and without wrap.
    b_q = {};
    repeat (300) b_q.push_back(4095);
    run_job_b("wide_max", r);
    check("wide_max_const", 32'(r), 32'(179924));
    b_q = {};
    repeat (300) b_q.push_back(int'($urandom_range(4095, 0)));
    run_job_b("wide_rnd", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
